// File: rtl/bin_to_digits.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_digits
// Purpose  : Sequential binary-to-BCD converter (shift-add-3, one bit per
//            clock) with seven-segment display formatting: per-digit value,
//            decimal point and leading-zero blanking, plus overflow forcing.
// Revision : 1.0 - initial release
// ============================================================================
module bin_to_digits #(
    parameter int BIN_W   = 14,
    parameter int NDIGITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [BIN_W-1:0]       bin,
    input  logic [NDIGITS-1:0]     dp_pos,
    input  logic                   blank_lz,
    output logic                   busy,
    output logic                   done,
    output logic                   ovf,
    output logic [6*NDIGITS-1:0]   digits
);

    // Number of decimal digits needed to hold 2^w - 1.
    function automatic int f_num_digits(input int w);
        longint unsigned v;
        int              n;
        v = (64'd1 << w) - 64'd1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            if (v != 64'd0) begin
                n++;
                v = v / 64'd10;
            end
        end
        return n;
    endfunction

    // 10^n - 1, the largest value that fits on n display digits.
    function automatic int f_max_value(input int n);
        int p;
        p = 1;
        for (int k = 0; k < n; k++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

    localparam int C_NBCD_RAW = f_num_digits(BIN_W);
    // Accumulator is never narrower than the display so every digit has a nibble.
    localparam int C_NACC     = (C_NBCD_RAW > NDIGITS) ? C_NBCD_RAW : NDIGITS;
    localparam int C_CNT_W    = $clog2(BIN_W + 1);
    localparam logic [31:0]          C_MAXV     = 32'(f_max_value(NDIGITS));
    localparam logic [C_CNT_W-1:0]   C_CNT_LOAD = C_CNT_W'(BIN_W);
    localparam logic [C_CNT_W-1:0]   C_CNT_ONE  = C_CNT_W'(1);
    localparam logic [6*NDIGITS-1:0] C_DIG_RST  = {NDIGITS{6'b10_0000}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FORMAT = 2'd2
    } state_t;

    state_t                  state_q,  state_d;
    logic [BIN_W-1:0]        bin_sh_q, bin_sh_d;
    logic [4*C_NACC-1:0]     bcd_q,    bcd_d;
    logic [C_CNT_W-1:0]      cnt_q,    cnt_d;
    logic [NDIGITS-1:0]      dp_q,     dp_d;
    logic                    blz_q,    blz_d;
    logic                    ovfp_q,   ovfp_d;
    logic                    busy_q,   busy_d;
    logic                    done_q,   done_d;
    logic                    ovf_q,    ovf_d;
    logic [6*NDIGITS-1:0]    digits_q, digits_d;

    logic [4*C_NACC-1:0]     w_bcd_adj;
    logic [NDIGITS-1:0][3:0] w_val;
    logic [6*NDIGITS-1:0]    w_fmt;
    logic                    w_allz;
    logic                    w_dp_hi;
    logic                    w_blank;

    // Add-3 correction on every nibble that would overflow when doubled.
    always_comb begin
        w_bcd_adj = bcd_q;
        for (int n = 0; n < C_NACC; n++) begin
            if (bcd_q[4*n +: 4] >= 4'd5) begin
                w_bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
            end
        end
    end

    // Display formatting, scanned from the most significant digit down so the
    // all-zero and dp-seen flags accumulate over digits i..NDIGITS-1.
    always_comb begin
        w_fmt   = '0;
        w_allz  = 1'b1;
        w_dp_hi = 1'b0;
        w_blank = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            w_val[i] = ovfp_q ? 4'd9 : bcd_q[4*i +: 4];
        end
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            w_allz  = w_allz & (w_val[i] == 4'd0);
            w_dp_hi = w_dp_hi | dp_q[i];
            w_blank = blz_q & (i > 0) & w_allz & ~w_dp_hi;
            w_fmt[6*i +: 6] = {w_blank, dp_q[i], w_val[i]};
        end
    end

    // Next-state and register-update logic for the IDLE/SHIFT/FORMAT sequence.
    always_comb begin
        state_d  = state_q;
        bin_sh_d = bin_sh_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        dp_d     = dp_q;
        blz_d    = blz_q;
        ovfp_d   = ovfp_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        ovf_d    = ovf_q;
        digits_d = digits_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bin_sh_d = bin;
                    dp_d     = dp_pos;
                    blz_d    = blank_lz;
                    bcd_d    = '0;
                    ovfp_d   = (32'(bin) > C_MAXV);
                    cnt_d    = C_CNT_LOAD;
                    busy_d   = 1'b1;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {bcd_d, bin_sh_d} = {w_bcd_adj, bin_sh_q} << 1;
                cnt_d = cnt_q - C_CNT_ONE;
                if (cnt_q == C_CNT_ONE) begin
                    state_d = S_FORMAT;
                end
            end
            S_FORMAT: begin
                digits_d = w_fmt;
                ovf_d    = ovfp_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset takes effect immediately and aborts any conversion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            bin_sh_q <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            dp_q     <= '0;
            blz_q    <= 1'b0;
            ovfp_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            digits_q <= C_DIG_RST;
        end else begin
            state_q  <= state_d;
            bin_sh_q <= bin_sh_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            dp_q     <= dp_d;
            blz_q    <= blz_d;
            ovfp_q   <= ovfp_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            digits_q <= digits_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign ovf    = ovf_q;
    assign digits = digits_q;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_digits.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_to_digits
// Purpose  : Directed self-checking bench for bin_to_digits (BIN_W=14,
//            NDIGITS=4) covering reset, conversion, blanking, decimal point,
//            overflow, start handling and mid-run reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin_to_digits;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] bin;
    logic [3:0]  dp_pos;
    logic        blank_lz;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [23:0] digits;

    int checks   = 0;
    int failures = 0;

    bin_to_digits #(.BIN_W(14), .NDIGITS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin      (bin),
        .dp_pos   (dp_pos),
        .blank_lz (blank_lz),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .digits   (digits)
    );

    always #5 clk = ~clk;

    // Issue one start pulse and wait (bounded) for done. lat counts edges after
    // the start edge; poke >= 0 re-pulses start and changes bin mid-conversion.
    task automatic run_conv(input logic [13:0] b, input logic [3:0] dp, input logic blz,
                            input int poke, output int lat, output int busy_cyc);
        @(negedge clk);
        bin = b; dp_pos = dp; blank_lz = blz; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; busy_cyc = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cyc++;
            start = (lat == poke);
            if (lat == poke) bin = 14'd5555;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; bin = '0; dp_pos = '0; blank_lz = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (digits !== 24'h820820) begin failures++; $display("FAIL reset_digits: got %h expected %h", digits, 24'h820820); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_convert;
        int lat, bc;
        run_conv(14'd1234, 4'b0000, 1'b1, -1, lat, bc);
        checks++; if (lat !== 15) begin failures++; $display("FAIL conv_latency: got %0d expected 15", lat); end
        checks++; if (bc !== 15) begin failures++; $display("FAIL conv_busy_cycles: got %0d expected 15", bc); end
        checks++; if (digits !== {6'h01, 6'h02, 6'h03, 6'h04}) begin failures++; $display("FAIL conv_1234_digits: got %h expected %h", digits, {6'h01, 6'h02, 6'h03, 6'h04}); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL conv_ovf: got %b expected 0", ovf); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL conv_busy_at_done: got %b expected 0", busy); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL conv_done_pulse: got %b expected 0", done); end
        checks++; if (digits !== {6'h01, 6'h02, 6'h03, 6'h04}) begin failures++; $display("FAIL conv_digits_hold: got %h expected %h", digits, {6'h01, 6'h02, 6'h03, 6'h04}); end
    endtask

    task automatic test_blanking;
        int lat, bc;
        run_conv(14'd7, 4'b0000, 1'b1, -1, lat, bc);
        checks++; if (digits !== {6'h20, 6'h20, 6'h20, 6'h07}) begin failures++; $display("FAIL blank_7_lz: got %h expected %h", digits, {6'h20, 6'h20, 6'h20, 6'h07}); end
        run_conv(14'd7, 4'b0000, 1'b0, -1, lat, bc);
        checks++; if (digits !== {6'h00, 6'h00, 6'h00, 6'h07}) begin failures++; $display("FAIL blank_7_nolz: got %h expected %h", digits, {6'h00, 6'h00, 6'h00, 6'h07}); end
        run_conv(14'd0, 4'b0000, 1'b1, -1, lat, bc);
        checks++; if (digits !== {6'h20, 6'h20, 6'h20, 6'h00}) begin failures++; $display("FAIL blank_0_lz: got %h expected %h", digits, {6'h20, 6'h20, 6'h20, 6'h00}); end
        run_conv(14'd305, 4'b0000, 1'b1, -1, lat, bc);
        checks++; if (digits !== {6'h20, 6'h03, 6'h00, 6'h05}) begin failures++; $display("FAIL blank_305_inner_zero: got %h expected %h", digits, {6'h20, 6'h03, 6'h00, 6'h05}); end
    endtask

    task automatic test_dp;
        int lat, bc;
        run_conv(14'd5, 4'b0010, 1'b1, -1, lat, bc);
        checks++; if (digits !== {6'h20, 6'h20, 6'h10, 6'h05}) begin failures++; $display("FAIL dp_5_pos1: got %h expected %h", digits, {6'h20, 6'h20, 6'h10, 6'h05}); end
        run_conv(14'd987, 4'b0100, 1'b1, -1, lat, bc);
        checks++; if (digits !== {6'h20, 6'h19, 6'h08, 6'h07}) begin failures++; $display("FAIL dp_987_pos2: got %h expected %h", digits, {6'h20, 6'h19, 6'h08, 6'h07}); end
    endtask

    task automatic test_overflow;
        int lat, bc;
        run_conv(14'd10000, 4'b0000, 1'b1, -1, lat, bc);
        checks++; if (lat !== 15) begin failures++; $display("FAIL ovf_latency: got %0d expected 15", lat); end
        checks++; if (digits !== {6'h09, 6'h09, 6'h09, 6'h09}) begin failures++; $display("FAIL ovf_10000_digits: got %h expected %h", digits, {6'h09, 6'h09, 6'h09, 6'h09}); end
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_10000_flag: got %b expected 1", ovf); end
        run_conv(14'd9999, 4'b0000, 1'b1, -1, lat, bc);
        checks++; if (digits !== {6'h09, 6'h09, 6'h09, 6'h09}) begin failures++; $display("FAIL ovf_9999_digits: got %h expected %h", digits, {6'h09, 6'h09, 6'h09, 6'h09}); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_9999_flag: got %b expected 0", ovf); end
        run_conv(14'd16383, 4'b0000, 1'b1, -1, lat, bc);
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_16383_flag: got %b expected 1", ovf); end
        run_conv(14'd42, 4'b0000, 1'b1, -1, lat, bc);
        checks++; if (digits !== {6'h20, 6'h20, 6'h04, 6'h02}) begin failures++; $display("FAIL ovf_clear_42_digits: got %h expected %h", digits, {6'h20, 6'h20, 6'h04, 6'h02}); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear_42_flag: got %b expected 0", ovf); end
    endtask

    task automatic test_ignore_start;
        int lat, bc, extra;
        run_conv(14'd1234, 4'b0000, 1'b1, 5, lat, bc);
        checks++; if (lat !== 15) begin failures++; $display("FAIL ignore_latency: got %0d expected 15", lat); end
        checks++; if (digits !== {6'h01, 6'h02, 6'h03, 6'h04}) begin failures++; $display("FAIL ignore_digits: got %h expected %h", digits, {6'h01, 6'h02, 6'h03, 6'h04}); end
        extra = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (done === 1'b1) extra++;
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL ignore_extra_done: got %0d expected 0", extra); end
    endtask

    task automatic test_back_to_back;
        int first, second, lat;
        first = -1; second = -1;
        @(negedge clk);
        bin = 14'd321; dp_pos = 4'b0000; blank_lz = 1'b1; start = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                if (first < 0) first = n;
                else if (second < 0) second = n;
            end
        end
        checks++; if (first !== 15) begin failures++; $display("FAIL b2b_first_done: got %0d expected 15", first); end
        checks++; if (second !== 31) begin failures++; $display("FAIL b2b_second_done: got %0d expected 31", second); end
        checks++; if (digits !== {6'h20, 6'h03, 6'h02, 6'h01}) begin failures++; $display("FAIL b2b_digits: got %h expected %h", digits, {6'h20, 6'h03, 6'h02, 6'h01}); end
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_drain_timeout: got done=%b expected 1", done); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int lat, bc, seen;
        run_conv(14'd10000, 4'b0000, 1'b1, -1, lat, bc);
        @(negedge clk);
        bin = 14'd4321; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (digits !== 24'h820820) begin failures++; $display("FAIL midrst_digits: got %h expected %h", digits, 24'h820820); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL midrst_done: got %b expected 0", done); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL midrst_ovf: got %b expected 0", ovf); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int n = 0; n < 25; n++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL midrst_no_done: got %0d expected 0", seen); end
        run_conv(14'd42, 4'b0000, 1'b1, -1, lat, bc);
        checks++; if (digits !== {6'h20, 6'h20, 6'h04, 6'h02}) begin failures++; $display("FAIL midrst_recover: got %h expected %h", digits, {6'h20, 6'h20, 6'h04, 6'h02}); end
    endtask

    initial begin
        test_reset();
        test_convert();
        test_blanking();
        test_dp();
        test_overflow();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
